// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: steers camera pixels into two line FIFOs (ping-pong) and tracks committed lines.
// Ports:
//   clk, rst_n                     rising-edge clock, synchronous active-low reset
//   i_vsync, i_href                frame sync and line-valid from the sensor
//   i_pix_valid, i_pix_data        pixel strobe and pixel word
//   o_fifo1_wr_en, o_fifo2_wr_en   write strobes into line FIFO 1 / 2 (one cycle after the pixel)
//   o_fifo_wr_data                 word written alongside the strobe
//   i_fifo1_full, i_fifo2_full     FIFO backpressure; pixels hitting a full FIFO are dropped
//   i_rd_en, i_rd_choose           pop from the read side, 0 = FIFO 1, 1 = FIFO 2
//   o_line_rdy                     bit b set while FIFO b+1 holds a complete line
//   o_line_len1, o_line_len2       remaining words of the committed line in each FIFO
//   o_irq_line, i_irq_clr          line-committed interrupt and its clear (set wins)
//   o_fifo_flush                   one-cycle pulse at frame start
//   o_ovf_err, o_rd_err            sticky: pixel discarded / pop from a buffer with no line
//   o_line_cnt                     lines committed since frame start
module line_buf_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int LINE_PIX   = 640,
    parameter int CNT_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_vsync,
    input  logic                  i_href,
    input  logic                  i_pix_valid,
    input  logic [DATA_WIDTH-1:0] i_pix_data,
    output logic                  o_fifo1_wr_en,
    output logic                  o_fifo2_wr_en,
    output logic [DATA_WIDTH-1:0] o_fifo_wr_data,
    input  logic                  i_fifo1_full,
    input  logic                  i_fifo2_full,
    input  logic                  i_rd_en,
    input  logic                  i_rd_choose,
    output logic [1:0]            o_line_rdy,
    output logic [CNT_W-1:0]      o_line_len1,
    output logic [CNT_W-1:0]      o_line_len2,
    output logic                  o_irq_line,
    input  logic                  i_irq_clr,
    output logic                  o_fifo_flush,
    output logic                  o_ovf_err,
    output logic                  o_rd_err,
    output logic [CNT_W-1:0]      o_line_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_LINE, S_WR_LINE, S_LINE_DONE} state_t;

    state_t                    state_q, state_d;
    logic                      vsync_q, href_q;
    // sel/tgt: 0 = FIFO 1, 1 = FIFO 2
    logic                      sel_q, sel_d, tgt_q, tgt_d, drop_q, drop_d;
    logic [CNT_W-1:0]          pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic [1:0]                wr_q, wr_d, rdy_q, rdy_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [1:0][CNT_W-1:0]     len_q, len_d;
    logic                      irq_q, irq_d, flush_q, flush_d, ovf_q, ovf_d, rd_err_q, rd_err_d;
    logic                      frame_start, line_end, pix_ok;

    assign frame_start = i_vsync & ~vsync_q;
    assign line_end    = href_q & ~i_href;
    assign pix_ok      = ~drop_q & (pix_cnt_q < CNT_W'(LINE_PIX)) & ~(tgt_q ? i_fifo2_full : i_fifo1_full);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        tgt_d      = tgt_q;
        drop_d     = drop_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        wr_d       = 2'b00;
        wdata_d    = wdata_q;
        rdy_d      = rdy_q;
        len_d      = len_q;
        irq_d      = irq_q & ~i_irq_clr;
        flush_d    = frame_start;
        ovf_d      = ovf_q;
        rd_err_d   = rd_err_q;
        // A committed line can only land in a buffer whose rdy bit is clear, so a pop
        // never races a commit on the same buffer.
        if (i_rd_en) begin
            if (rdy_q[i_rd_choose]) begin
                len_d[i_rd_choose] = len_q[i_rd_choose] - CNT_W'(1);
                if (len_q[i_rd_choose] == CNT_W'(1))
                    rdy_d[i_rd_choose] = 1'b0;
            end else begin
                rd_err_d = 1'b1;
            end
        end
        case (state_q)
            S_WAIT_LINE: begin
                if (i_href) begin
                    state_d   = S_WR_LINE;
                    tgt_d     = sel_q;
                    drop_d    = rdy_q[sel_q];
                    pix_cnt_d = '0;
                end
            end
            S_WR_LINE: begin
                if (line_end)
                    state_d = S_LINE_DONE;
                if (i_href && i_pix_valid) begin
                    if (pix_ok) begin
                        wr_d[tgt_q] = 1'b1;
                        wdata_d     = i_pix_data;
                        pix_cnt_d   = pix_cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_LINE_DONE: begin
                state_d = S_WAIT_LINE;
                if (pix_cnt_q != '0 && !drop_q) begin
                    rdy_d[tgt_q] = 1'b1;
                    len_d[tgt_q] = pix_cnt_q;
                    line_cnt_d   = line_cnt_q + CNT_W'(1);
                    irq_d        = 1'b1;
                    sel_d        = ~sel_q;
                end
            end
            default: ;
        endcase
        // Frame start overrides everything, including a line ending in the same cycle.
        if (frame_start) begin
            state_d    = S_WAIT_LINE;
            sel_d      = 1'b0;
            line_cnt_d = '0;
            rdy_d      = '0;
            len_d      = '0;
            wr_d       = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            sel_q      <= 1'b0;
            tgt_q      <= 1'b0;
            drop_q     <= 1'b0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            wr_q       <= 2'b00;
            wdata_q    <= '0;
            rdy_q      <= 2'b00;
            len_q      <= '0;
            irq_q      <= 1'b0;
            flush_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= i_vsync;
            href_q     <= i_href;
            sel_q      <= sel_d;
            tgt_q      <= tgt_d;
            drop_q     <= drop_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            rdy_q      <= rdy_d;
            len_q      <= len_d;
            irq_q      <= irq_d;
            flush_q    <= flush_d;
            ovf_q      <= ovf_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign o_fifo1_wr_en  = wr_q[0];
    assign o_fifo2_wr_en  = wr_q[1];
    assign o_fifo_wr_data = wdata_q;
    assign o_line_rdy     = rdy_q;
    assign o_line_len1    = len_q[0];
    assign o_line_len2    = len_q[1];
    assign o_irq_line     = irq_q;
    assign o_fifo_flush   = flush_q;
    assign o_ovf_err      = ovf_q;
    assign o_rd_err       = rd_err_q;
    assign o_line_cnt     = line_cnt_q;
endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: directed and randomized line traffic against a line-level reference model.
module tb_line_buf_ctrl;
    localparam int DW = 16;
    localparam int LP = 20;
    localparam int CW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, i_vsync, i_href, i_pix_valid, i_fifo1_full, i_fifo2_full;
    logic          i_rd_en, i_rd_choose, i_irq_clr;
    logic [DW-1:0] i_pix_data, o_fifo_wr_data;
    logic          o_fifo1_wr_en, o_fifo2_wr_en, o_irq_line, o_fifo_flush, o_ovf_err, o_rd_err;
    logic [1:0]    o_line_rdy;
    logic [CW-1:0] o_line_len1, o_line_len2, o_line_cnt;

    line_buf_ctrl #(.DATA_WIDTH(DW), .LINE_PIX(LP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_vsync(i_vsync), .i_href(i_href),
        .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data),
        .o_fifo1_wr_en(o_fifo1_wr_en), .o_fifo2_wr_en(o_fifo2_wr_en), .o_fifo_wr_data(o_fifo_wr_data),
        .i_fifo1_full(i_fifo1_full), .i_fifo2_full(i_fifo2_full),
        .i_rd_en(i_rd_en), .i_rd_choose(i_rd_choose), .o_line_rdy(o_line_rdy),
        .o_line_len1(o_line_len1), .o_line_len2(o_line_len2), .o_irq_line(o_irq_line),
        .i_irq_clr(i_irq_clr), .o_fifo_flush(o_fifo_flush), .o_ovf_err(o_ovf_err),
        .o_rd_err(o_rd_err), .o_line_cnt(o_line_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: buffer status as seen at line/pop granularity.
    logic [DW-1:0]         exp_q1[$], exp_q2[$];
    logic [1:0]            m_rdy;
    logic [1:0][CW-1:0]    m_len;
    logic [CW-1:0]         m_cnt;
    bit                    m_sel, m_irq, m_ovf, m_rderr;
    int                    w1_cnt = 0, w2_cnt = 0, flush_cnt = 0;
    bit                    mon_off = 1'b0;
    logic [DW-1:0]         md1, md2;

    // Every write strobe must match the next pixel the model expects in that FIFO.
    always @(negedge clk) begin
        if (!mon_off) begin
            if (o_fifo_flush) flush_cnt++;
            if (o_fifo1_wr_en || o_fifo2_wr_en) begin
                checks++;
                if (o_fifo1_wr_en && o_fifo2_wr_en) begin errors++; $display("FAIL dual_wr got both strobes want one at %0t", $time); end
            end
            if (o_fifo1_wr_en) begin
                w1_cnt++;
                checks++;
                if (exp_q1.size() == 0) begin errors++; $display("FAIL wr1_data got write %h want none at %0t", o_fifo_wr_data, $time); end
                else begin
                    md1 = exp_q1.pop_front();
                    if (o_fifo_wr_data !== md1) begin errors++; $display("FAIL wr1_data got %h want %h at %0t", o_fifo_wr_data, md1, $time); end
                end
            end
            if (o_fifo2_wr_en) begin
                w2_cnt++;
                checks++;
                if (exp_q2.size() == 0) begin errors++; $display("FAIL wr2_data got write %h want none at %0t", o_fifo_wr_data, $time); end
                else begin
                    md2 = exp_q2.pop_front();
                    if (o_fifo_wr_data !== md2) begin errors++; $display("FAIL wr2_data got %h want %h at %0t", o_fifo_wr_data, md2, $time); end
                end
            end
        end
    end

    function automatic void model_reset();
        m_rdy = '0; m_len = '0; m_cnt = '0; m_sel = 1'b0;
        m_irq = 1'b0; m_ovf = 1'b0; m_rderr = 1'b0;
        exp_q1.delete(); exp_q2.delete();
    endfunction

    function automatic void model_frame();
        m_rdy = '0; m_len = '0; m_cnt = '0; m_sel = 1'b0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; i_vsync = 1'b0; i_href = 1'b0; i_pix_valid = 1'b0; i_pix_data = '0;
        i_fifo1_full = 1'b0; i_fifo2_full = 1'b0; i_rd_en = 1'b0; i_rd_choose = 1'b0; i_irq_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic frame_seq();
        @(posedge clk); #1 i_vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_vsync = 1'b0;
        model_frame();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One sensor line: href leads the first pixel by a cycle; pixels may be spaced by gaps.
    task automatic send_line(input int n, input int full_pct, input int max_gap, input bit clr_at_end, input bit vs_at_end);
        bit tgt, drop, f;
        int acc;
        logic [DW-1:0] d;
        tgt = m_sel; drop = m_rdy[tgt]; acc = 0;
        @(posedge clk); #1 i_href = 1'b1;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1 i_pix_valid = 1'b0; end
            @(posedge clk); #1;
            d = DW'($urandom);
            f = (int'($urandom_range(0, 99)) < full_pct);
            i_pix_valid = 1'b1; i_pix_data = d; i_fifo1_full = f; i_fifo2_full = f;
            if (!drop && acc < LP && !f) begin
                acc++;
                if (tgt) exp_q2.push_back(d); else exp_q1.push_back(d);
            end else m_ovf = 1'b1;
        end
        @(posedge clk); #1;
        i_href = 1'b0; i_pix_valid = 1'b0; i_fifo1_full = 1'b0; i_fifo2_full = 1'b0;
        if (vs_at_end) begin
            i_vsync = 1'b1;
            model_frame();
        end else begin
            if (clr_at_end) m_irq = 1'b0;
            if (acc > 0 && !drop) begin
                m_rdy[tgt] = 1'b1; m_len[tgt] = CW'(acc); m_cnt++; m_irq = 1'b1; m_sel = ~m_sel;
            end
        end
        @(posedge clk); #1 i_irq_clr = clr_at_end; i_vsync = 1'b0;
        @(posedge clk); #1 i_irq_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input bit c);
        @(posedge clk); #1 i_rd_en = 1'b1; i_rd_choose = c;
        @(posedge clk); #1 i_rd_en = 1'b0;
        if (m_rdy[c]) begin
            m_len[c] = m_len[c] - CW'(1);
            if (m_len[c] == '0) m_rdy[c] = 1'b0;
        end else m_rderr = 1'b1;
    endtask

    task automatic irq_clr_pulse();
        @(posedge clk); #1 i_irq_clr = 1'b1;
        @(posedge clk); #1 i_irq_clr = 1'b0;
        m_irq = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({o_fifo1_wr_en, o_fifo2_wr_en} !== 2'b00) begin errors++; $display("FAIL reset_wr got %b want 00", {o_fifo1_wr_en, o_fifo2_wr_en}); end
        checks++; if (o_fifo_wr_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", o_fifo_wr_data); end
        checks++; if (o_line_rdy !== 2'b00) begin errors++; $display("FAIL reset_rdy got %b want 00", o_line_rdy); end
        checks++; if ({o_line_len1, o_line_len2, o_line_cnt} !== '0) begin errors++; $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", o_line_len1, o_line_len2, o_line_cnt); end
        checks++; if ({o_irq_line, o_fifo_flush, o_ovf_err, o_rd_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {o_irq_line, o_fifo_flush, o_ovf_err, o_rd_err}); end
    endtask

    task automatic test_two_lines();
        int w1, w2, fl;
        w1 = w1_cnt; w2 = w2_cnt; fl = flush_cnt;
        frame_seq();
        checks++; if (flush_cnt - fl !== 1) begin errors++; $display("FAIL frame_flush got %0d pulses want 1", flush_cnt - fl); end
        send_line(8, 0, 0, 1'b0, 1'b0);
        checks++; if (w1_cnt - w1 !== 8 || w2_cnt - w2 !== 0) begin errors++; $display("FAIL line1_wr got %0d/%0d want 8/0", w1_cnt - w1, w2_cnt - w2); end
        send_line(8, 0, 2, 1'b0, 1'b0);
        checks++; if (w1_cnt - w1 !== 8 || w2_cnt - w2 !== 8) begin errors++; $display("FAIL line2_wr got %0d/%0d want 8/8", w1_cnt - w1, w2_cnt - w2); end
        checks++; if (o_line_rdy !== 2'b11) begin errors++; $display("FAIL two_rdy got %b want 11", o_line_rdy); end
        checks++; if (o_line_len1 !== CW'(8) || o_line_len2 !== CW'(8)) begin errors++; $display("FAIL two_len got %0d/%0d want 8/8", o_line_len1, o_line_len2); end
        checks++; if (o_line_cnt !== CW'(2)) begin errors++; $display("FAIL two_cnt got %0d want 2", o_line_cnt); end
        checks++; if (o_irq_line !== 1'b1 || o_ovf_err !== 1'b0) begin errors++; $display("FAIL two_flags got irq %b ovf %b want 1 0", o_irq_line, o_ovf_err); end
    endtask

    task automatic test_drop();
        int w1, w2;
        w1 = w1_cnt; w2 = w2_cnt;
        send_line(8, 0, 0, 1'b0, 1'b0);
        checks++; if (w1_cnt != w1 || w2_cnt != w2) begin errors++; $display("FAIL drop_wr got %0d/%0d writes want 0/0", w1_cnt - w1, w2_cnt - w2); end
        checks++; if (o_ovf_err !== 1'b1) begin errors++; $display("FAIL drop_ovf got %b want 1", o_ovf_err); end
        checks++; if (o_line_cnt !== CW'(2) || o_line_rdy !== 2'b11) begin errors++; $display("FAIL drop_state got cnt %0d rdy %b want 2 11", o_line_cnt, o_line_rdy); end
    endtask

    task automatic test_reads();
        int w1;
        for (int i = 0; i < 8; i++) begin
            do_read(1'b0);
            checks++; if (o_line_len1 !== CW'(7 - i)) begin errors++; $display("FAIL pop_len1 got %0d want %0d", o_line_len1, 7 - i); end
            checks++; if (o_line_rdy[0] !== 1'(i < 7)) begin errors++; $display("FAIL pop_rdy0 got %b want %b after pop %0d", o_line_rdy[0], i < 7, i + 1); end
        end
        w1 = w1_cnt;
        send_line(5, 0, 1, 1'b0, 1'b0);
        checks++; if (w1_cnt - w1 !== 5) begin errors++; $display("FAIL refill_wr1 got %0d want 5", w1_cnt - w1); end
        checks++; if (o_line_rdy !== 2'b11 || o_line_len1 !== CW'(5) || o_line_cnt !== CW'(3)) begin errors++; $display("FAIL refill_state got rdy %b len1 %0d cnt %0d want 11 5 3", o_line_rdy, o_line_len1, o_line_cnt); end
        checks++; if (o_rd_err !== 1'b0) begin errors++; $display("FAIL refill_rderr got %b want 0", o_rd_err); end
    endtask

    task automatic test_overflow();
        int w1;
        do_reset();
        checks++; if (o_ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", o_ovf_err); end
        frame_seq();
        w1 = w1_cnt;
        send_line(LP + 5, 0, 0, 1'b0, 1'b0);
        checks++; if (w1_cnt - w1 !== LP) begin errors++; $display("FAIL long_wr got %0d want %0d", w1_cnt - w1, LP); end
        checks++; if (o_line_len1 !== CW'(LP) || o_line_rdy !== 2'b01) begin errors++; $display("FAIL long_len got %0d rdy %b want %0d 01", o_line_len1, o_line_rdy, LP); end
        checks++; if (o_ovf_err !== 1'b1) begin errors++; $display("FAIL long_ovf got %b want 1", o_ovf_err); end
    endtask

    task automatic test_irq_rderr();
        send_line(6, 0, 0, 1'b1, 1'b0);
        checks++; if (o_irq_line !== 1'b1 || o_line_rdy !== 2'b11) begin errors++; $display("FAIL irq_setwins got irq %b rdy %b want 1 11", o_irq_line, o_line_rdy); end
        irq_clr_pulse();
        checks++; if (o_irq_line !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", o_irq_line); end
        repeat (6) do_read(1'b1);
        checks++; if (o_rd_err !== 1'b0 || o_line_rdy !== 2'b01 || o_line_len2 !== '0) begin errors++; $display("FAIL drain2 got rderr %b rdy %b len2 %0d want 0 01 0", o_rd_err, o_line_rdy, o_line_len2); end
        do_read(1'b1);
        checks++; if (o_rd_err !== 1'b1 || o_line_len2 !== '0) begin errors++; $display("FAIL empty_pop got rderr %b len2 %0d want 1 0", o_rd_err, o_line_len2); end
    endtask

    task automatic test_flush();
        int w1, fl;
        fl = flush_cnt;
        frame_seq();
        checks++; if (flush_cnt - fl !== 1) begin errors++; $display("FAIL flush_pulse got %0d pulses want 1", flush_cnt - fl); end
        checks++; if (o_line_rdy !== 2'b00 || o_line_cnt !== '0 || o_line_len1 !== '0) begin errors++; $display("FAIL flush_clear got rdy %b cnt %0d len1 %0d want 00 0 0", o_line_rdy, o_line_cnt, o_line_len1); end
        w1 = w1_cnt;
        send_line(4, 0, 0, 1'b0, 1'b0);
        checks++; if (w1_cnt - w1 !== 4 || o_line_rdy !== 2'b01) begin errors++; $display("FAIL flush_next got %0d wr1 rdy %b want 4 01", w1_cnt - w1, o_line_rdy); end
    endtask

    task automatic test_vs_line_end();
        int w1, fl;
        fl = flush_cnt;
        send_line(5, 0, 0, 1'b0, 1'b1);
        checks++; if (flush_cnt - fl !== 1) begin errors++; $display("FAIL vsend_flush got %0d pulses want 1", flush_cnt - fl); end
        checks++; if (o_line_rdy !== 2'b00 || o_line_cnt !== '0 || o_line_len2 !== '0) begin errors++; $display("FAIL vsend_discard got rdy %b cnt %0d len2 %0d want 00 0 0", o_line_rdy, o_line_cnt, o_line_len2); end
        w1 = w1_cnt;
        send_line(3, 0, 0, 1'b0, 1'b0);
        checks++; if (w1_cnt - w1 !== 3 || o_line_len1 !== CW'(3)) begin errors++; $display("FAIL vsend_next got %0d wr1 len1 %0d want 3 3", w1_cnt - w1, o_line_len1); end
    endtask

    task automatic test_random();
        do_reset();
        frame_seq();
        for (int it = 0; it < 40; it++) begin
            int a;
            a = int'($urandom_range(0, 9));
            if (a < 5) send_line(int'($urandom_range(0, LP + 3)), ($urandom_range(0, 1) == 1) ? 20 : 0,
                                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
            else if (a < 8) repeat ($urandom_range(1, 8)) do_read(1'($urandom_range(0, 1)));
            else if (a < 9) irq_clr_pulse();
            else frame_seq();
            checks++; if (o_line_rdy !== m_rdy) begin errors++; $display("FAIL rnd_rdy it %0d got %b want %b", it, o_line_rdy, m_rdy); end
            checks++; if (o_line_len1 !== m_len[0] || o_line_len2 !== m_len[1]) begin errors++; $display("FAIL rnd_len it %0d got %0d/%0d want %0d/%0d", it, o_line_len1, o_line_len2, m_len[0], m_len[1]); end
            checks++; if (o_line_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt it %0d got %0d want %0d", it, o_line_cnt, m_cnt); end
            checks++; if ({o_irq_line, o_ovf_err, o_rd_err} !== {m_irq, m_ovf, m_rderr}) begin errors++; $display("FAIL rnd_flags it %0d got %b want %b", it, {o_irq_line, o_ovf_err, o_rd_err}, {m_irq, m_ovf, m_rderr}); end
            checks++; if (exp_q1.size() + exp_q2.size() != 0) begin errors++; $display("FAIL rnd_missing it %0d got %0d pending writes want 0", it, exp_q1.size() + exp_q2.size()); end
        end
    endtask

    task automatic test_reset_midline();
        int w1, w2;
        frame_seq();
        mon_off = 1'b1;
        @(posedge clk); #1 i_href = 1'b1;
        repeat (4) begin @(posedge clk); #1 i_pix_valid = 1'b1; i_pix_data = DW'($urandom); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        w1 = w1_cnt; w2 = w2_cnt;
        mon_off = 1'b0;
        checks++; if ({o_fifo1_wr_en, o_fifo2_wr_en} !== 2'b00) begin errors++; $display("FAIL midrst_wr got %b want 00", {o_fifo1_wr_en, o_fifo2_wr_en}); end
        repeat (6) begin @(posedge clk); #1 i_pix_data = DW'($urandom); end
        i_href = 1'b0; i_pix_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (w1_cnt != w1 || w2_cnt != w2) begin errors++; $display("FAIL midrst_after got %0d/%0d writes want 0/0", w1_cnt - w1, w2_cnt - w2); end
        checks++; if ({o_line_rdy, o_line_cnt, o_ovf_err, o_irq_line} !== '0) begin errors++; $display("FAIL midrst_state got rdy %b cnt %0d ovf %b irq %b want all 0", o_line_rdy, o_line_cnt, o_ovf_err, o_irq_line); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_two_lines();
        test_drop();
        test_reads();
        test_overflow();
        test_irq_rderr();
        test_flush();
        test_vs_line_end();
        test_random();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
